csr_trap_unit: RTL and testbench

Parametrised machine-mode CSR file with trap entry/return sequencing, interrupt arbitration and a configurable bank of 64-bit hardware performance counters. It sits beside the execute stage. It serves Zicsr accesses, latches trap state on exceptions and interrupts, and drives a one-cycle PC redirect to fetch on trap entry and on `mret`.

---
 rtl/csr_trap_unit.sv | 258 +++++++++++++++++++++++++
 tb/tb_csr_trap_unit.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/csr_trap_unit.sv
`default_nettype none
// ---- csr_trap_unit: machine-mode CSR file with trap/mret sequencing, interrupt
// ---- arbitration and 64-bit performance counters.                 Rev 1.0 ----
module csr_trap_unit #(
  parameter int          NUM_HPM     = 4,
  parameter logic [31:0] RESET_MTVEC = 32'h0000_0000,
  parameter bit          VECTORED_EN = 1'b1
) (
  input  logic                                    clk,
  input  logic                                    rst_n,
  input  logic                                    csr_req_i,
  input  logic [2:0]                              func3_i,
  input  logic [4:0]                              csr_imm_i,
  input  logic [11:0]                             csr_addr_i,
  input  logic [31:0]                             csr_data_in,
  output logic [31:0]                             csr_data_out,
  output logic                                    csr_ack_o,
  output logic                                    csr_illegal_o,
  input  logic                                    trap_i,
  input  logic                                    trap_is_irq_i,
  input  logic [4:0]                              trap_cause_i,
  input  logic [31:0]                             trap_pc_i,
  input  logic [31:0]                             trap_tval_i,
  input  logic                                    mret_i,
  input  logic                                    irq_ext_i,
  input  logic                                    irq_timer_i,
  input  logic                                    irq_soft_i,
  output logic                                    irq_pending_o,
  input  logic                                    instruction_finished,
  input  logic [((NUM_HPM > 0) ? NUM_HPM : 1)-1:0] hpm_event_i,
  output logic                                    redirect_o,
  output logic [31:0]                             redirect_pc_o
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACK   = 2'd1,
    ST_REDIR = 2'd2
  } state_e;

  localparam logic [31:0] MISA_VAL = 32'h4000_1105;
  localparam logic [31:0] INH_MASK = 32'h1 |
      (((NUM_HPM == 0) ? 32'h0 : ((32'h1 << NUM_HPM) - 32'h1)) << 3);

  state_e      state_q, state_d;
  logic        mstatus_mie_q, mstatus_mie_d;
  logic        mstatus_mpie_q, mstatus_mpie_d;
  logic [2:0]  mie_q, mie_d;  // {MEIE, MTIE, MSIE}
  logic [2:0]  mip_q;         // {MEIP, MTIP, MSIP}
  logic [31:0] mtvec_q, mtvec_d;
  logic [31:0] mscratch_q, mscratch_d;
  logic [31:0] mepc_q, mepc_d;
  logic [31:0] mcause_q, mcause_d;
  logic [31:0] mtval_q, mtval_d;
  logic [31:0] mcountinhibit_q, mcountinhibit_d;
  logic        illegal_q, illegal_d;
  logic [31:0] redirect_pc_q, redirect_pc_d;

  logic [63:0] w_cnt [32];
  logic        w_take_trap, w_take_mret, w_take_csr;
  logic        w_is_cnt, w_known, w_wr_intent, w_illegal, w_do_wr;
  logic        w_cnt_lo_sel, w_cnt_hi_sel;
  logic [31:0] w_rdata, w_src, w_wdata, w_trap_target;
  logic [2:0]  w_irq_en;
  logic [4:0]  w_irq_cause, w_cause;

  // Only one event class is honoured per cycle; lower-priority ones are dropped.
  assign w_take_trap = trap_i;
  assign w_take_mret = mret_i & ~trap_i;
  assign w_take_csr  = csr_req_i & ~trap_i & ~mret_i;

  assign w_is_cnt = ((csr_addr_i[11:8] == 4'hC) || (csr_addr_i[11:8] == 4'hB)) &&
                    (csr_addr_i[6:5] == 2'b00);

  always_comb begin
    w_known = 1'b1;
    w_rdata = 32'h0;
    if (w_is_cnt) begin
      w_rdata = csr_addr_i[7] ? w_cnt[csr_addr_i[4:0]][63:32] : w_cnt[csr_addr_i[4:0]][31:0];
    end else begin
      case (csr_addr_i)
        12'hF11, 12'hF12, 12'hF13, 12'h310: w_rdata = 32'h0;
        12'h300: w_rdata = {19'b0, 2'b11, 3'b0, mstatus_mpie_q, 3'b0, mstatus_mie_q, 3'b0};
        12'h301: w_rdata = MISA_VAL;
        12'h304: w_rdata = {20'b0, mie_q[2], 3'b0, mie_q[1], 3'b0, mie_q[0], 3'b0};
        12'h305: w_rdata = mtvec_q;
        12'h320: w_rdata = mcountinhibit_q;
        12'h340: w_rdata = mscratch_q;
        12'h341: w_rdata = mepc_q;
        12'h342: w_rdata = mcause_q;
        12'h343: w_rdata = mtval_q;
        12'h344: w_rdata = {20'b0, mip_q[2], 3'b0, mip_q[1], 3'b0, mip_q[0], 3'b0};
        default: w_known = 1'b0;
      endcase
    end
  end

  assign csr_data_out = w_rdata;

  // Set/clear with an all-zero rs1/uimm field is a pure read.
  assign w_src       = func3_i[2] ? {27'b0, csr_imm_i} : csr_data_in;
  assign w_wr_intent = (func3_i[1:0] == 2'b01) || (func3_i[1] && (csr_imm_i != 5'd0));
  assign w_illegal   = ~w_known || (func3_i[1:0] == 2'b00) ||
                       ((csr_addr_i[11:10] == 2'b11) && w_wr_intent);
  assign w_do_wr     = w_take_csr & ~w_illegal & w_wr_intent;

  always_comb begin
    case (func3_i[1:0])
      2'b10:   w_wdata = w_rdata | w_src;
      2'b11:   w_wdata = w_rdata & ~w_src;
      default: w_wdata = w_src;
    endcase
  end

  assign w_irq_en      = mip_q & mie_q;
  assign irq_pending_o = mstatus_mie_q & (|w_irq_en);

  always_comb begin
    if (w_irq_en[2])      w_irq_cause = 5'd11;
    else if (w_irq_en[0]) w_irq_cause = 5'd3;
    else if (w_irq_en[1]) w_irq_cause = 5'd7;
    else                  w_irq_cause = 5'd0;
  end

  assign w_cause       = trap_is_irq_i ? w_irq_cause : trap_cause_i;
  assign w_trap_target = {mtvec_q[31:2], 2'b00} +
                         ((trap_is_irq_i && (mtvec_q[1:0] == 2'b01)) ? {25'b0, w_cause, 2'b00} : 32'h0);

  always_comb begin
    state_d         = ST_IDLE;
    mstatus_mie_d   = mstatus_mie_q;
    mstatus_mpie_d  = mstatus_mpie_q;
    mie_d           = mie_q;
    mtvec_d         = mtvec_q;
    mscratch_d      = mscratch_q;
    mepc_d          = mepc_q;
    mcause_d        = mcause_q;
    mtval_d         = mtval_q;
    mcountinhibit_d = mcountinhibit_q;
    illegal_d       = 1'b0;
    redirect_pc_d   = redirect_pc_q;
    if (w_take_trap) begin
      state_d        = ST_REDIR;
      mepc_d         = {trap_pc_i[31:1], 1'b0};
      mtval_d        = trap_is_irq_i ? 32'h0 : trap_tval_i;
      mcause_d       = {trap_is_irq_i, 26'b0, w_cause};
      mstatus_mpie_d = mstatus_mie_q;
      mstatus_mie_d  = 1'b0;
      redirect_pc_d  = w_trap_target;
    end else if (w_take_mret) begin
      state_d        = ST_REDIR;
      mstatus_mie_d  = mstatus_mpie_q;
      mstatus_mpie_d = 1'b1;
      redirect_pc_d  = mepc_q;
    end else if (w_take_csr) begin
      state_d   = ST_ACK;
      illegal_d = w_illegal;
      if (w_do_wr) begin
        case (csr_addr_i)
          12'h300: begin
            mstatus_mie_d  = w_wdata[3];
            mstatus_mpie_d = w_wdata[7];
          end
          12'h304: mie_d           = {w_wdata[11], w_wdata[7], w_wdata[3]};
          12'h305: mtvec_d         = {w_wdata[31:2], 1'b0, (VECTORED_EN ? w_wdata[0] : 1'b0)};
          12'h320: mcountinhibit_d = w_wdata & INH_MASK;
          12'h340: mscratch_d      = w_wdata;
          12'h341: mepc_d          = {w_wdata[31:1], 1'b0};
          12'h342: mcause_d        = w_wdata;
          12'h343: mtval_d         = w_wdata;
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q         <= ST_IDLE;
      mstatus_mie_q   <= 1'b0;
      mstatus_mpie_q  <= 1'b0;
      mie_q           <= 3'b0;
      mip_q           <= 3'b0;
      mtvec_q         <= RESET_MTVEC;
      mscratch_q      <= 32'h0;
      mepc_q          <= 32'h0;
      mcause_q        <= 32'h0;
      mtval_q         <= 32'h0;
      mcountinhibit_q <= 32'h0;
      illegal_q       <= 1'b0;
      redirect_pc_q   <= 32'h0;
    end else begin
      state_q         <= state_d;
      mstatus_mie_q   <= mstatus_mie_d;
      mstatus_mpie_q  <= mstatus_mpie_d;
      mie_q           <= mie_d;
      mip_q           <= {irq_ext_i, irq_timer_i, irq_soft_i};
      mtvec_q         <= mtvec_d;
      mscratch_q      <= mscratch_d;
      mepc_q          <= mepc_d;
      mcause_q        <= mcause_d;
      mtval_q         <= mtval_d;
      mcountinhibit_q <= mcountinhibit_d;
      illegal_q       <= illegal_d;
      redirect_pc_q   <= redirect_pc_d;
    end
  end

  assign csr_ack_o     = (state_q == ST_ACK);
  assign csr_illegal_o = illegal_q;
  assign redirect_o    = (state_q == ST_REDIR);
  assign redirect_pc_o = redirect_pc_q;

  // Counter slot N maps to addresses B00+N / B80+N and their C-space shadows.
  assign w_cnt_lo_sel = w_do_wr && (csr_addr_i[11:5] == 7'b1011_000);
  assign w_cnt_hi_sel = w_do_wr && (csr_addr_i[11:5] == 7'b1011_100);

  generate
    for (genvar gi = 0; gi < 32; gi++) begin : g_cnt
      if ((gi == 0) || (gi == 2) || ((gi >= 3) && (gi < 3 + NUM_HPM))) begin : g_impl
        localparam logic [4:0] IDX = 5'(gi);
        logic [63:0] cnt_q, cnt_d;
        logic        inc;
        logic        wr_lo, wr_hi;

        if (gi == 0) begin : g_cycle
          assign inc = 1'b1;
        end else if (gi == 2) begin : g_instret
          assign inc = instruction_finished;
        end else begin : g_hpm
          assign inc = hpm_event_i[gi-3];
        end

        assign wr_lo = w_cnt_lo_sel && (csr_addr_i[4:0] == IDX);
        assign wr_hi = w_cnt_hi_sel && (csr_addr_i[4:0] == IDX);

        // A write to one half wins over this cycle's increment.
        always_comb begin
          cnt_d = cnt_q;
          if (wr_lo)                               cnt_d[31:0]  = w_wdata;
          else if (wr_hi)                          cnt_d[63:32] = w_wdata;
          else if (inc && !mcountinhibit_q[gi])    cnt_d        = cnt_q + 64'd1;
        end

        always_ff @(posedge clk) begin
          if (!rst_n) cnt_q <= 64'h0;
          else        cnt_q <= cnt_d;
        end

        assign w_cnt[gi] = cnt_q;
      end else begin : g_none
        assign w_cnt[gi] = 64'h0;
      end
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_csr_trap_unit.sv
`default_nettype none
// tb_csr_trap_unit: directed vectors; expected acks/redirects are queued by the
// stimulus and checked by an independent monitor when the DUT responds.
module tb_csr_trap_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        csr_req_i;
  logic [2:0]  func3_i;
  logic [4:0]  csr_imm_i;
  logic [11:0] csr_addr_i;
  logic [31:0] csr_data_in;
  logic [31:0] csr_data_out;
  logic        csr_ack_o;
  logic        csr_illegal_o;
  logic        trap_i;
  logic        trap_is_irq_i;
  logic [4:0]  trap_cause_i;
  logic [31:0] trap_pc_i;
  logic [31:0] trap_tval_i;
  logic        mret_i;
  logic        irq_ext_i, irq_timer_i, irq_soft_i;
  logic        irq_pending_o;
  logic        instruction_finished;
  logic [3:0]  hpm_event_i;
  logic        redirect_o;
  logic [31:0] redirect_pc_o;

  always #5 clk = ~clk;

  csr_trap_unit #(
    .NUM_HPM    (4),
    .RESET_MTVEC(32'h0000_0000),
    .VECTORED_EN(1'b1)
  ) dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .csr_req_i           (csr_req_i),
    .func3_i             (func3_i),
    .csr_imm_i           (csr_imm_i),
    .csr_addr_i          (csr_addr_i),
    .csr_data_in         (csr_data_in),
    .csr_data_out        (csr_data_out),
    .csr_ack_o           (csr_ack_o),
    .csr_illegal_o       (csr_illegal_o),
    .trap_i              (trap_i),
    .trap_is_irq_i       (trap_is_irq_i),
    .trap_cause_i        (trap_cause_i),
    .trap_pc_i           (trap_pc_i),
    .trap_tval_i         (trap_tval_i),
    .mret_i              (mret_i),
    .irq_ext_i           (irq_ext_i),
    .irq_timer_i         (irq_timer_i),
    .irq_soft_i          (irq_soft_i),
    .irq_pending_o       (irq_pending_o),
    .instruction_finished(instruction_finished),
    .hpm_event_i         (hpm_event_i),
    .redirect_o          (redirect_o),
    .redirect_pc_o       (redirect_pc_o)
  );

  typedef struct packed {
    logic        ill;
    logic        chk_rd;
    logic [31:0] rd;
  } exp_t;

  exp_t        ack_q[$];
  logic [31:0] obs_q[$];
  logic [31:0] redir_q[$];
  exp_t        mon_e;
  logic [31:0] mon_o;
  logic [31:0] mon_pc;
  int          checks   = 0;
  int          failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: actual=%h required=%h", name, act, req);
    end
  endtask

  // Monitor: consumes one expectation per ack / redirect the DUT presents.
  always @(negedge clk) begin
    if (csr_ack_o === 1'b1) begin
      if (ack_q.size() == 0 || obs_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_ack: actual=1 required=0 at %0t", $time);
      end else begin
        mon_e = ack_q.pop_front();
        mon_o = obs_q.pop_front();
        check("ack_illegal", {31'b0, csr_illegal_o}, {31'b0, mon_e.ill});
        if (mon_e.chk_rd) check("ack_rdata", mon_o, mon_e.rd);
      end
    end
    if (redirect_o === 1'b1) begin
      if (redir_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_redirect: actual=%h required=none", redirect_pc_o);
      end else begin
        mon_pc = redir_q.pop_front();
        check("redirect_pc", redirect_pc_o, mon_pc);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_csr(input logic [2:0] f3, input logic [4:0] imm, input logic [11:0] addr,
                        input logic [31:0] din, input logic ill, input logic chk,
                        input logic [31:0] exp_rd);
    exp_t e;
    e.ill = ill;
    e.chk_rd = chk;
    e.rd = exp_rd;
    csr_req_i   = 1'b1;
    func3_i     = f3;
    csr_imm_i   = imm;
    csr_addr_i  = addr;
    csr_data_in = din;
    ack_q.push_back(e);
    @(negedge clk);
    obs_q.push_back(csr_data_out);
    tick(1);
    csr_req_i = 1'b0;
  endtask

  task automatic rd_csr(input logic [11:0] addr, input logic [31:0] exp_rd);
    do_csr(3'b110, 5'd0, addr, 32'h0, 1'b0, 1'b1, exp_rd);
  endtask

  task automatic do_trap(input logic irq, input logic [4:0] cause, input logic [31:0] pc,
                         input logic [31:0] tval, input logic [31:0] exp_pc);
    trap_i        = 1'b1;
    trap_is_irq_i = irq;
    trap_cause_i  = cause;
    trap_pc_i     = pc;
    trap_tval_i   = tval;
    redir_q.push_back(exp_pc);
    tick(1);
    trap_i        = 1'b0;
    trap_is_irq_i = 1'b0;
  endtask

  task automatic check_pending(input string name, input logic req);
    @(negedge clk);
    check(name, {31'b0, irq_pending_o}, {31'b0, req});
    tick(1);
  endtask

  initial begin
    rst_n = 1'b0;
    csr_req_i = 1'b0; func3_i = 3'b0; csr_imm_i = 5'd0; csr_addr_i = 12'h0; csr_data_in = 32'h0;
    trap_i = 1'b0; trap_is_irq_i = 1'b0; trap_cause_i = 5'd0; trap_pc_i = 32'h0; trap_tval_i = 32'h0;
    mret_i = 1'b0; irq_ext_i = 1'b0; irq_timer_i = 1'b0; irq_soft_i = 1'b0;
    instruction_finished = 1'b0; hpm_event_i = 4'b0;

    tick(3);
    @(negedge clk);
    check("rst_ack", {31'b0, csr_ack_o}, 32'd0);
    check("rst_illegal", {31'b0, csr_illegal_o}, 32'd0);
    check("rst_redirect", {31'b0, redirect_o}, 32'd0);
    check("rst_redirect_pc", redirect_pc_o, 32'h0);
    check("rst_irq_pending", {31'b0, irq_pending_o}, 32'd0);
    tick(1);
    rst_n = 1'b1;

    rd_csr(12'h300, 32'h0000_1800);
    rd_csr(12'h305, 32'h0000_0000);
    rd_csr(12'h301, 32'h4000_1105);
    do_csr(3'b001, 5'd0, 12'h340, 32'hDEAD_BEEF, 1'b0, 1'b1, 32'h0);
    rd_csr(12'h340, 32'hDEAD_BEEF);

    do_csr(3'b110, 5'd8, 12'h300, 32'h0, 1'b0, 1'b1, 32'h0000_1800);
    do_csr(3'b111, 5'd0, 12'h300, 32'hFFFF_FFFF, 1'b0, 1'b1, 32'h0000_1808);
    do_csr(3'b011, 5'd0, 12'h300, 32'hFFFF_FFFF, 1'b0, 1'b1, 32'h0000_1808);
    rd_csr(12'h300, 32'h0000_1808);

    do_csr(3'b001, 5'd0, 12'h305, 32'h1000_0001, 1'b0, 1'b1, 32'h0);
    do_csr(3'b001, 5'd0, 12'h304, 32'hFFFF_FFFF, 1'b0, 1'b1, 32'h0);
    do_csr(3'b001, 5'd0, 12'h304, 32'h0000_0800, 1'b0, 1'b1, 32'h0000_0888);
    rd_csr(12'h305, 32'h1000_0001);

    irq_ext_i = 1'b1;
    check_pending("irq_pending_before_sync", 1'b0);
    check_pending("irq_pending_set", 1'b1);
    rd_csr(12'h344, 32'h0000_0800);

    do_trap(1'b1, 5'd5, 32'h0000_0200, 32'h0000_1234, 32'h1000_002C);
    rd_csr(12'h342, 32'h8000_000B);
    rd_csr(12'h341, 32'h0000_0200);
    rd_csr(12'h343, 32'h0000_0000);
    rd_csr(12'h300, 32'h0000_1880);
    check_pending("irq_pending_masked", 1'b0);

    mret_i = 1'b1;
    redir_q.push_back(32'h0000_0200);
    tick(1);
    mret_i = 1'b0;
    rd_csr(12'h300, 32'h0000_1888);
    check_pending("irq_pending_after_mret", 1'b1);
    irq_ext_i = 1'b0;

    // Exception colliding with a CSR write: only the redirect may appear.
    csr_req_i = 1'b1; func3_i = 3'b001; csr_addr_i = 12'h340; csr_data_in = 32'h1111_1111;
    do_trap(1'b0, 5'd2, 32'h0000_0301, 32'h0000_0BAD, 32'h1000_0000);
    csr_req_i = 1'b0;
    rd_csr(12'h340, 32'hDEAD_BEEF);
    rd_csr(12'h342, 32'h0000_0002);
    rd_csr(12'h341, 32'h0000_0300);
    rd_csr(12'h343, 32'h0000_0BAD);
    rd_csr(12'h300, 32'h0000_1880);

    do_csr(3'b001, 5'd0, 12'hB00, 32'hFFFF_FFFF, 1'b0, 1'b0, 32'h0);
    rd_csr(12'hB00, 32'hFFFF_FFFF);
    rd_csr(12'hB80, 32'h0000_0001);
    do_csr(3'b110, 5'd1, 12'h320, 32'h0, 1'b0, 1'b1, 32'h0);
    rd_csr(12'hB00, 32'h0000_0002);
    tick(3);
    rd_csr(12'hB00, 32'h0000_0002);
    rd_csr(12'hC80, 32'h0000_0001);

    do_csr(3'b001, 5'd0, 12'hC00, 32'h0000_0005, 1'b1, 1'b1, 32'h0000_0002);
    do_csr(3'b001, 5'd0, 12'h7FF, 32'h0000_0005, 1'b1, 1'b1, 32'h0);
    do_csr(3'b000, 5'd0, 12'h340, 32'h0000_0005, 1'b1, 1'b1, 32'hDEAD_BEEF);
    rd_csr(12'hB00, 32'h0000_0002);
    rd_csr(12'h340, 32'hDEAD_BEEF);
    rd_csr(12'hC07, 32'h0);
    do_csr(3'b001, 5'd0, 12'hB07, 32'h0000_0005, 1'b0, 1'b1, 32'h0);
    rd_csr(12'hB07, 32'h0);

    instruction_finished = 1'b1;
    tick(3);
    instruction_finished = 1'b0;
    rd_csr(12'hB02, 32'h0000_0003);
    rd_csr(12'hC82, 32'h0);

    do_csr(3'b001, 5'd0, 12'h320, 32'hFFFF_FFFF, 1'b0, 1'b1, 32'h0000_0001);
    rd_csr(12'h320, 32'h0000_0079);
    hpm_event_i = 4'b0001;
    tick(2);
    hpm_event_i = 4'b0000;
    rd_csr(12'hB03, 32'h0);
    do_csr(3'b111, 5'd8, 12'h320, 32'h0, 1'b0, 1'b1, 32'h0000_0079);
    hpm_event_i = 4'b0001;
    tick(2);
    hpm_event_i = 4'b0000;
    rd_csr(12'hB03, 32'h0000_0002);
    rd_csr(12'hB04, 32'h0);

    // Reset arriving with a request, then with a trap: neither may respond.
    rst_n = 1'b0;
    csr_req_i = 1'b1; func3_i = 3'b001; csr_addr_i = 12'h340; csr_data_in = 32'h55;
    tick(1);
    csr_req_i = 1'b0;
    trap_i = 1'b1; trap_pc_i = 32'h0000_0400;
    @(negedge clk);
    check("rst_mid_ack", {31'b0, csr_ack_o}, 32'd0);
    tick(1);
    trap_i = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_mid_redirect", {31'b0, redirect_o}, 32'd0);
    check("rst_mid_redirect_pc", redirect_pc_o, 32'h0);
    tick(1);
    rd_csr(12'h340, 32'h0);
    rd_csr(12'h305, 32'h0);
    rd_csr(12'h300, 32'h0000_1800);

    tick(3);
    check("pending_acks", ack_q.size(), 32'd0);
    check("pending_redirects", redir_q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
